cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 64 ++++++
 tb/tb_cp0.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// cp0: coprocessor-0 status/cause/EPC/PRId registers with interrupt request generation
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_1220
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [29:0] PC,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [5:0]  ip;
    logic [4:0]  exccode;
    logic [29:0] epc;

    assign IntReq = (|(HWInt & im)) & ie & ~exl;
    assign EPC    = epc;

    // register file update: an interrupt entry pre-empts any write, EXLClr beats a written EXL bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im      <= 6'b0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            ip      <= 6'b0;
            exccode <= 5'b0;
            epc     <= 30'b0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl     <= 1'b1;
                epc     <= PC;
                exccode <= 5'd0;
            end else begin
                if (We && A2 == 5'd12) begin
                    im  <= DIn[15:10];
                    ie  <= DIn[0];
                    exl <= EXLClr ? 1'b0 : DIn[1];
                end else if (EXLClr) begin
                    exl <= 1'b0;
                end
                if (We && A2 == 5'd14)
                    epc <= DIn[31:2];
            end
        end
    end

    // mfc0 read mux: SR, Cause, EPC, PRId, zero elsewhere
    always_comb begin
        DOut = A1 == 5'd12 ? {16'b0, im, 8'b0, exl, ie} :
               A1 == 5'd13 ? {16'b0, ip, 3'b0, exccode, 2'b0} :
               A1 == 5'd14 ? {epc, 2'b00} :
               A1 == 5'd15 ? PRID : 32'b0;
    end
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: scoreboard-driven self-checking bench for cp0
module tb_cp0;
    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [29:0] PC;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  a1;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic [5:0]  m_ip;
    logic [29:0] m_epc;

    cp0 dut (
        .clk(clk),
        .reset(reset),
        .A1(A1),
        .A2(A2),
        .DIn(DIn),
        .We(We),
        .PC(PC),
        .HWInt(HWInt),
        .EXLClr(EXLClr),
        .IntReq(IntReq),
        .EPC(EPC),
        .DOut(DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // kind 0: DOut at address a1, kind 1: IntReq, kind 2: EPC output
    task automatic push(input string tag, input int kind, input logic [4:0] a1, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.a1 = a1;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) A1 = e.a1;
            #1;
            if (e.kind == 0) check(e.tag, DOut, e.exp);
            else if (e.kind == 1) check(e.tag, {31'b0, IntReq}, e.exp);
            else check(e.tag, {2'b0, EPC}, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic m_req();
        return (|(HWInt & m_im)) & m_ie & ~m_exl;
    endfunction

    function automatic logic [31:0] m_dout(input logic [4:0] a);
        return a == 5'd12 ? {16'b0, m_im, 8'b0, m_exl, m_ie} :
               a == 5'd13 ? {16'b0, m_ip, 10'b0} :
               a == 5'd14 ? {m_epc, 2'b00} :
               a == 5'd15 ? 32'h0000_1220 : 32'b0;
    endfunction

    task automatic m_step();
        logic req;
        req = m_req();
        m_ip = HWInt;
        if (req) begin
            m_exl = 1'b1;
            m_epc = PC;
        end else begin
            if (We && A2 == 5'd12) begin
                m_im = DIn[15:10];
                m_ie = DIn[0];
                m_exl = EXLClr ? 1'b0 : DIn[1];
            end else if (EXLClr) begin
                m_exl = 1'b0;
            end
            if (We && A2 == 5'd14) m_epc = DIn[31:2];
        end
    endtask

    initial begin
        reset = 1'b0;
        A1 = 5'd0;
        A2 = 5'd0;
        DIn = 32'b0;
        We = 1'b0;
        PC = 30'b0;
        HWInt = 6'h3F;
        EXLClr = 1'b0;
        tick();
        tick();
        push("rst_prid", 0, 5'd15, 32'h0000_1220);
        push("rst_sr", 0, 5'd12, 32'h0);
        push("rst_cause", 0, 5'd13, 32'h0);
        push("rst_epc_rd", 0, 5'd14, 32'h0);
        push("rst_intreq", 1, 5'd0, 32'h0);
        push("rst_epc", 2, 5'd0, 32'h0);
        drain();
        reset = 1'b1;
        tick();
        push("post_rst_intreq", 1, 5'd0, 32'h0);
        drain();
        HWInt = 6'h00;
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0C01;
        tick();
        We = 1'b0;
        push("sr_write", 0, 5'd12, 32'h0000_0C01);
        HWInt = 6'b000001; PC = 30'h0000_0C40;
        push("int_same_cycle", 1, 5'd0, 32'h1);
        drain();
        tick();
        push("int_exl_sr", 0, 5'd12, 32'h0000_0C03);
        push("int_intreq_off", 1, 5'd0, 32'h0);
        push("int_epc", 2, 5'd0, 32'h0000_0C40);
        push("int_epc_rd", 0, 5'd14, 32'h0000_3100);
        push("int_cause", 0, 5'd13, 32'h0000_0400);
        drain();
        EXLClr = 1'b1;
        push("handler_masked", 1, 5'd0, 32'h0);
        drain();
        tick();
        EXLClr = 1'b0;
        push("eret_intreq", 1, 5'd0, 32'h1);
        push("eret_sr", 0, 5'd12, 32'h0000_0C01);
        drain();
        PC = 30'h0000_0123; We = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
        tick();
        We = 1'b0;
        push("int_drops_epc_wr", 2, 5'd0, 32'h0000_0123);
        push("int_drops_epc_rd", 0, 5'd14, 32'h0000_048C);
        drain();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        PC = 30'h0000_0055; We = 1'b1; A2 = 5'd12; DIn = 32'h0;
        tick();
        We = 1'b0;
        push("int_drops_sr_wr", 0, 5'd12, 32'h0000_0C03);
        push("int_epc2", 2, 5'd0, 32'h0000_0055);
        drain();
        HWInt = 6'b000010; EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
        tick();
        push("exlclr_wins", 0, 5'd12, 32'h0000_0401);
        push("ip_delayed", 0, 5'd13, 32'h0000_0800);
        push("masked_line", 1, 5'd0, 32'h0);
        drain();
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15;
        tick();
        EXLClr = 1'b0;
        A2 = 5'd14; DIn = 32'hABCD_1234;
        tick();
        We = 1'b0;
        push("exlclr_noop", 0, 5'd12, 32'h0000_0401);
        push("wr13_ignored", 0, 5'd13, 32'h0000_0800);
        push("wr15_ignored", 0, 5'd15, 32'h0000_1220);
        push("epc_wr_rd", 0, 5'd14, 32'hABCD_1234);
        push("epc_wr_out", 2, 5'd0, 32'h2AF3_448D);
        push("unmapped_rd", 0, 5'd3, 32'h0);
        drain();
        HWInt = 6'b000001; PC = 30'h0000_03FF;
        tick();
        push("pre_rst_epc", 2, 5'd0, 32'h0000_03FF);
        drain();
        tick();
        #1 reset = 1'b0;
        push("async_intreq", 1, 5'd0, 32'h0);
        push("async_epc", 2, 5'd0, 32'h0);
        push("async_sr", 0, 5'd12, 32'h0);
        push("async_cause", 0, 5'd13, 32'h0);
        push("async_epc_rd", 0, 5'd14, 32'h0);
        drain();
        tick();
        reset = 1'b1;
        m_im = 6'b0; m_exl = 1'b0; m_ie = 1'b0; m_ip = 6'b0; m_epc = 30'b0;
        for (int i = 0; i < 300; i++) begin
            logic [4:0] a;
            We = ($urandom_range(0, 2) != 0);
            A2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ($urandom_range(0, 1) ? 5'd12 : 5'd14);
            DIn = $urandom;
            EXLClr = ($urandom_range(0, 3) == 0);
            HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
            PC = 30'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            push("rnd_intreq", 1, 5'd0, {31'b0, m_req()});
            push("rnd_dout", 0, a, m_dout(a));
            push("rnd_epc", 2, 5'd0, {2'b0, m_epc});
            drain();
            m_step();
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
